// File: rtl/alu_pkg.sv
// alu_pkg: ALUCode values, MIPS opcode/funct constants and widths shared by the issue stage and the ALU
package alu_pkg;
  localparam int DW = 32;
  localparam int CW = 5;
  localparam logic [CW-1:0] ALU_ADD  = 5'd0;
  localparam logic [CW-1:0] ALU_AND  = 5'd1;
  localparam logic [CW-1:0] ALU_XOR  = 5'd2;
  localparam logic [CW-1:0] ALU_OR   = 5'd3;
  localparam logic [CW-1:0] ALU_NOR  = 5'd4;
  localparam logic [CW-1:0] ALU_SUB  = 5'd5;
  localparam logic [CW-1:0] ALU_ANDI = 5'd6;
  localparam logic [CW-1:0] ALU_XORI = 5'd7;
  localparam logic [CW-1:0] ALU_ORI  = 5'd8;
  localparam logic [CW-1:0] ALU_SLL  = 5'd16;
  localparam logic [CW-1:0] ALU_SRL  = 5'd17;
  localparam logic [CW-1:0] ALU_SRA  = 5'd18;
  localparam logic [CW-1:0] ALU_SLT  = 5'd19;
  localparam logic [CW-1:0] ALU_SLTU = 5'd20;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS instruction -> ALUCode and operand pair
// Ports: i_instr/i_rs/i_rt in; o_alucode, o_a, o_b, o_ovf_en (trapping op), o_illegal out.
module alu_decode
  import alu_pkg::*;
(
  input  logic [DW-1:0] i_instr,
  input  logic [DW-1:0] i_rs,
  input  logic [DW-1:0] i_rt,
  output logic [CW-1:0] o_alucode,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic          o_ovf_en,
  output logic          o_illegal
);
  logic [5:0] w_op, w_funct;
  logic [DW-1:0] w_sext, w_zext, w_shamt, w_rsamt;
  logic w_unused;
  assign w_op = i_instr[31:26];
  assign w_funct = i_instr[5:0];
  assign w_sext = {{16{i_instr[15]}}, i_instr[15:0]};
  assign w_zext = {16'b0, i_instr[15:0]};
  assign w_shamt = {27'b0, i_instr[10:6]};
  assign w_rsamt = {27'b0, i_rs[4:0]};
  // register specifiers arrive already resolved as i_rs/i_rt
  assign w_unused = ^i_instr[25:16];
  always_comb begin
    o_alucode = ALU_ADD;
    o_a = i_rs;
    o_b = i_rt;
    o_ovf_en = 1'b0;
    o_illegal = 1'b0;
    if (w_op == OP_RTYPE) begin
      case (w_funct)
        F_ADD, F_ADDU: o_ovf_en = (w_funct == F_ADD);
        F_SUB, F_SUBU: begin o_alucode = ALU_SUB; o_ovf_en = (w_funct == F_SUB); end
        F_AND:  o_alucode = ALU_AND;
        F_OR:   o_alucode = ALU_OR;
        F_XOR:  o_alucode = ALU_XOR;
        F_NOR:  o_alucode = ALU_NOR;
        F_SLT:  o_alucode = ALU_SLT;
        F_SLTU: o_alucode = ALU_SLTU;
        F_SLL:  begin o_alucode = ALU_SLL; o_a = w_shamt; end
        F_SRL:  begin o_alucode = ALU_SRL; o_a = w_shamt; end
        F_SRA:  begin o_alucode = ALU_SRA; o_a = w_shamt; end
        F_SLLV: begin o_alucode = ALU_SLL; o_a = w_rsamt; end
        F_SRLV: begin o_alucode = ALU_SRL; o_a = w_rsamt; end
        F_SRAV: begin o_alucode = ALU_SRA; o_a = w_rsamt; end
        default: o_illegal = 1'b1;
      endcase
    end else begin
      o_b = w_sext;
      case (w_op)
        OP_ADDI:  o_ovf_en = 1'b1;
        OP_ADDIU: o_alucode = ALU_ADD;
        OP_SLTI:  o_alucode = ALU_SLT;
        OP_SLTIU: o_alucode = ALU_SLTU;
        OP_ANDI:  begin o_alucode = ALU_ANDI; o_b = w_zext; end
        OP_ORI:   begin o_alucode = ALU_ORI; o_b = w_zext; end
        OP_XORI:  begin o_alucode = ALU_XORI; o_b = w_zext; end
        // lui is a left shift of the immediate by 16
        OP_LUI:   begin o_alucode = ALU_SLL; o_a = 32'd16; o_b = w_zext; end
        default:  o_illegal = 1'b1;
      endcase
    end
    if (o_illegal) begin
      o_a = '0;
      o_b = '0;
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX issue stage holding the EX slot and the overflow-trap flop
// Ports: clk, rst_n (async low); id_valid/id_instr/id_rs_data/id_rt_data in, id_ready out;
// ex_stall/ex_flush in; ex_valid/ex_alucode/ex_a/ex_b/ex_ovf_en/ex_illegal out;
// alu_overflow in; ovf_trap out.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [DW-1:0] id_instr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          ex_stall,
  input  logic          ex_flush,
  output logic          ex_valid,
  output logic [CW-1:0] ex_alucode,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic          ex_ovf_en,
  output logic          ex_illegal,
  input  logic          alu_overflow,
  output logic          ovf_trap
);
  logic [CW-1:0] w_alucode;
  logic [DW-1:0] w_a, w_b;
  logic w_ovf_en, w_illegal;
  logic r_valid, r_ovf_en, r_illegal, r_trap;
  logic [CW-1:0] r_alucode;
  logic [DW-1:0] r_a, r_b;
  alu_decode u_dec (
    .i_instr(id_instr),
    .i_rs(id_rs_data),
    .i_rt(id_rt_data),
    .o_alucode(w_alucode),
    .o_a(w_a),
    .o_b(w_b),
    .o_ovf_en(w_ovf_en),
    .o_illegal(w_illegal)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_alucode <= '0;
      r_a <= '0;
      r_b <= '0;
      r_ovf_en <= 1'b0;
      r_illegal <= 1'b0;
      r_trap <= 1'b0;
    end else begin
      // trap only when the overflowing op actually leaves the slot
      r_trap <= r_valid & r_ovf_en & alu_overflow & ~ex_stall & ~ex_flush;
      if (ex_flush) begin
        r_valid <= 1'b0;
        r_alucode <= '0;
        r_a <= '0;
        r_b <= '0;
        r_ovf_en <= 1'b0;
        r_illegal <= 1'b0;
      end else if (!ex_stall) begin
        r_valid <= id_valid;
        if (id_valid) begin
          r_alucode <= w_alucode;
          r_a <= w_a;
          r_b <= w_b;
          r_ovf_en <= w_ovf_en;
          r_illegal <= w_illegal;
        end
      end
    end
  end
  assign id_ready = ~ex_stall;
  assign ex_valid = r_valid;
  assign ex_alucode = r_alucode;
  assign ex_a = r_a;
  assign ex_b = r_b;
  assign ex_ovf_en = r_ovf_en;
  assign ex_illegal = r_illegal;
  assign ovf_trap = r_trap;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with a scoreboard queue and an independent negedge monitor
module tb_alu_issue_stage;
  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic        ovf_en;
    logic        illegal;
    logic        trap;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic id_ready;
  logic [31:0] id_instr = '0, id_rs_data = '0, id_rt_data = '0;
  logic ex_stall = 1'b0, ex_flush = 1'b0;
  logic ex_valid, ex_ovf_en, ex_illegal, ovf_trap;
  logic [4:0] ex_alucode;
  logic [31:0] ex_a, ex_b;
  logic alu_overflow = 1'b0;
  exp_t q[$];
  logic exp_trap = 1'b0;
  int checks = 0;
  int errors = 0;
  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .ex_stall(ex_stall), .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_alucode(ex_alucode), .ex_a(ex_a), .ex_b(ex_b),
    .ex_ovf_en(ex_ovf_en), .ex_illegal(ex_illegal),
    .alu_overflow(alu_overflow), .ovf_trap(ovf_trap)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(logic [4:0] c, logic [31:0] a, logic [31:0] b, logic oe, logic il, logic tr);
    mk = '{code: c, a: a, b: b, ovf_en: oe, illegal: il, trap: tr};
  endfunction
  task automatic check(string name, logic [79:0] got, logic [79:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  task automatic issue(logic [31:0] instr, logic [31:0] rs, logic [31:0] rt, logic ovf, exp_t e);
    id_valid = 1'b1;
    id_instr = instr;
    id_rs_data = rs;
    id_rt_data = rt;
    q.push_back(e);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    alu_overflow = ovf;
  endtask
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (ovf_trap !== exp_trap) begin
      errors++;
      $display("FAIL ovf_trap: got %0b expected %0b at %0t", ovf_trap, exp_trap, $time);
    end
    exp_trap = 1'b0;
    if (ex_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ex_valid: got 1 expected 0 at %0t", $time);
      end else begin
        e = q[0];
        if ({ex_alucode, ex_a, ex_b, ex_ovf_en, ex_illegal} !== {e.code, e.a, e.b, e.ovf_en, e.illegal}) begin
          errors++;
          $display("FAIL ex_payload: got code=%0d a=%h b=%h oe=%0b il=%0b expected code=%0d a=%h b=%h oe=%0b il=%0b at %0t",
                   ex_alucode, ex_a, ex_b, ex_ovf_en, ex_illegal, e.code, e.a, e.b, e.ovf_en, e.illegal, $time);
        end
        if (ex_flush) void'(q.pop_front());
        else if (!ex_stall) begin
          void'(q.pop_front());
          exp_trap = e.trap;
        end
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 80'({ex_valid, ex_illegal, ex_ovf_en, ovf_trap, ex_alucode, ex_a, ex_b}), 80'd0);
    check("reset_id_ready", 80'(id_ready), 80'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'h00221820, 32'h40000000, 32'h40000000, 1'b1, mk(5'd0, 32'h40000000, 32'h40000000, 1'b1, 1'b0, 1'b1));
    issue(32'h00221821, 32'h40000000, 32'h40000000, 1'b1, mk(5'd0, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0));
    issue(32'h3C01FFFF, 32'h12345678, 32'h0, 1'b0, mk(5'd16, 32'h10, 32'h0000FFFF, 1'b0, 1'b0, 1'b0));
    issue(32'h00011103, 32'h0, 32'hFFFFE0FF, 1'b0, mk(5'd18, 32'h4, 32'hFFFFE0FF, 1'b0, 1'b0, 1'b0));
    issue(32'h3022E0FF, 32'hFF0C0E10, 32'h0, 1'b0, mk(5'd6, 32'hFF0C0E10, 32'h0000E0FF, 1'b0, 1'b0, 1'b0));
    issue(32'h00221822, 32'h5, 32'h7, 1'b0, mk(5'd5, 32'h5, 32'h7, 1'b1, 1'b0, 1'b0));
    issue(32'h2822FFFE, 32'h3, 32'h9, 1'b0, mk(5'd19, 32'h3, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0));
    issue(32'h2C228000, 32'h3, 32'h9, 1'b0, mk(5'd20, 32'h3, 32'hFFFF8000, 1'b0, 1'b0, 1'b0));
    issue(32'h34228001, 32'hA, 32'h0, 1'b0, mk(5'd8, 32'hA, 32'h00008001, 1'b0, 1'b0, 1'b0));
    issue(32'h38228001, 32'hB, 32'h0, 1'b0, mk(5'd7, 32'hB, 32'h00008001, 1'b0, 1'b0, 1'b0));
    issue(32'h00221806, 32'h123, 32'hF0, 1'b0, mk(5'd17, 32'h3, 32'hF0, 1'b0, 1'b0, 1'b0));
    issue(32'h0022182B, 32'h1, 32'h2, 1'b0, mk(5'd20, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0));
    issue(32'h00221827, 32'hF0F0, 32'h0F0F, 1'b0, mk(5'd4, 32'hF0F0, 32'h0F0F, 1'b0, 1'b0, 1'b0));
    issue(32'h00011140, 32'h0, 32'h1, 1'b0, mk(5'd16, 32'h5, 32'h1, 1'b0, 1'b0, 1'b0));
    issue(32'h0022183F, 32'h1, 32'h2, 1'b0, mk(5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
    issue(32'h20228000, 32'h80000000, 32'h0, 1'b1, mk(5'd0, 32'h80000000, 32'hFFFF8000, 1'b1, 1'b0, 1'b1));
    // stalled overflowing addi: no trap until it advances
    issue(32'h20228000, 32'h80000000, 32'h0, 1'b1, mk(5'd0, 32'h80000000, 32'hFFFF8000, 1'b1, 1'b0, 1'b1));
    ex_stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ex_stall = 1'b0;
    @(posedge clk);
    #1;
    // stall 3 cycles with fresh id_valid, then flush while still stalled
    issue(32'h00221820, 32'h40000000, 32'h40000000, 1'b1, mk(5'd0, 32'h40000000, 32'h40000000, 1'b1, 1'b0, 1'b1));
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_valid = 1'b1;
      id_instr = 32'h3C01FFFF;
      id_rs_data = 32'(i);
      #1;
      check("stall_id_ready", 80'(id_ready), 80'd0);
      @(posedge clk);
      #1;
    end
    ex_flush = 1'b1;
    @(posedge clk);
    #1;
    ex_flush = 1'b0;
    ex_stall = 1'b0;
    id_valid = 1'b0;
    alu_overflow = 1'b0;
    #1;
    check("flush_ex_valid", 80'(ex_valid), 80'd0);
    // flush with a new instruction: it is dropped
    issue(32'h3022E0FF, 32'hFF0C0E10, 32'h0, 1'b0, mk(5'd6, 32'hFF0C0E10, 32'h0000E0FF, 1'b0, 1'b0, 1'b0));
    ex_flush = 1'b1;
    id_valid = 1'b1;
    id_instr = 32'h3C01FFFF;
    #1;
    check("flush_id_ready", 80'(id_ready), 80'd1);
    @(posedge clk);
    #1;
    ex_flush = 1'b0;
    id_valid = 1'b0;
    @(posedge clk);
    #1;
    // trap pulse pending from add plus illegal slot, then async reset mid-cycle
    issue(32'h00221820, 32'h7FFFFFFF, 32'h1, 1'b1, mk(5'd0, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, 1'b1));
    issue(32'hFC000000, 32'h1, 32'h2, 1'b0, mk(5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 80'({ex_valid, ex_illegal, ex_ovf_en, ovf_trap, ex_alucode, ex_a, ex_b}), 80'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_outputs", 80'({ex_valid, ex_illegal, ex_ovf_en, ovf_trap, ex_alucode, ex_a, ex_b}), 80'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 80'(q.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
